// File: rtl/dm_cache_pkg.sv
// rtl/dm_cache_pkg.sv - shared types, widths and word select for the direct-mapped read cache
package dm_cache_pkg;
    localparam int CACHE_ADDR_W  = 15;
    localparam int CACHE_INDEX_W = 8;
    localparam int OFFSET_W      = 2;
    localparam int TAG_W         = CACHE_ADDR_W - CACHE_INDEX_W - 2;
    localparam int LINE_W        = 128;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_MEM_WAIT,
        S_REFILL,
        S_RESP
    } state_t;

    // Offset 0 lives in the most significant word of the block.
    function automatic logic [31:0] word_sel(input logic [LINE_W-1:0] block,
                                             input logic [OFFSET_W-1:0] offset);
        logic [31:0] w;
        case (offset)
            2'd0:    w = block[127:96];
            2'd1:    w = block[95:64];
            2'd2:    w = block[63:32];
            default: w = block[31:0];
        endcase
        return w;
    endfunction
endpackage

// File: rtl/dm_cache_if.sv
// rtl/dm_cache_if.sv - CPU load port, block memory port and statistics of the cache controller
interface dm_cache_if #(
    parameter int ADDR_W = 15,
    parameter int CNT_W  = 16
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              resp_valid;
    logic [31:0]       resp_data;
    logic              resp_hit;
    logic              flush;
    logic [ADDR_W-1:0] mem_addr;
    logic [127:0]      mem_rdata;
    logic [CNT_W-1:0]  hit_count;
    logic [CNT_W-1:0]  miss_count;

    modport master (
        output req_valid, req_addr, flush, mem_rdata,
        input  req_ready, resp_valid, resp_data, resp_hit, mem_addr, hit_count, miss_count
    );

    modport slave (
        input  req_valid, req_addr, flush, mem_rdata,
        output req_ready, resp_valid, resp_data, resp_hit, mem_addr, hit_count, miss_count
    );
endinterface

// File: rtl/dm_cache_lines.sv
// rtl/dm_cache_lines.sv - valid/tag/data line storage with index read, refill write and flush-all
module dm_cache_lines
    import dm_cache_pkg::*;
#(
    parameter int INDEX_W  = 8,
    parameter int TAG_BITS = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_flush,
    input  logic [INDEX_W-1:0]  i_rd_idx,
    output logic                o_rd_valid,
    output logic [TAG_BITS-1:0] o_rd_tag,
    output logic [LINE_W-1:0]   o_rd_data,
    input  logic                i_wr_en,
    input  logic [INDEX_W-1:0]  i_wr_idx,
    input  logic [TAG_BITS-1:0] i_wr_tag,
    input  logic [LINE_W-1:0]   i_wr_data
);
    localparam int LINES = 1 << INDEX_W;

    logic [LINES-1:0]    r_valid;
    logic [TAG_BITS-1:0] r_tag  [LINES];
    logic [LINE_W-1:0]   r_data [LINES];

    // Only the valid bits are cleared; stale tag/data are harmless once invalid.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_valid <= '0;
        end else if (i_wr_en) begin
            r_valid[i_wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_tag[i_wr_idx]  <= i_wr_tag;
            r_data[i_wr_idx] <= i_wr_data;
        end
    end

    assign o_rd_valid = r_valid[i_rd_idx];
    assign o_rd_tag   = r_tag[i_rd_idx];
    assign o_rd_data  = r_data[i_rd_idx];
endmodule

// File: rtl/dm_cache_ctrl.sv
// rtl/dm_cache_ctrl.sv - read-only direct-mapped cache controller: lookup FSM, refill and hit/miss statistics
module dm_cache_ctrl
    import dm_cache_pkg::*;
#(
    parameter int ADDR_W  = CACHE_ADDR_W,
    parameter int INDEX_W = CACHE_INDEX_W,
    parameter int MEM_LAT = 2,
    parameter int CNT_W   = 16
) (
    input logic       clk,
    input logic       rst,
    dm_cache_if.slave bus
);
    localparam int TAG_BITS = ADDR_W - INDEX_W - OFFSET_W;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [3:0]          r_lat_cnt;
    logic [LINE_W-1:0]   r_block;
    logic [31:0]         r_word;
    logic                r_word_hit;
    logic                r_req_ready;
    logic                r_resp_valid;
    logic [31:0]         r_resp_data;
    logic                r_resp_hit;
    logic [CNT_W-1:0]    r_hit_cnt;
    logic [CNT_W-1:0]    r_miss_cnt;

    logic [TAG_BITS-1:0] w_tag;
    logic [INDEX_W-1:0]  w_idx;
    logic [OFFSET_W-1:0] w_off;
    logic                w_line_valid;
    logic [TAG_BITS-1:0] w_line_tag;
    logic [LINE_W-1:0]   w_line_data;
    logic                w_hit;
    logic                w_flush;
    logic                w_refill;

    assign w_tag    = r_addr[ADDR_W-1:INDEX_W+OFFSET_W];
    assign w_idx    = r_addr[INDEX_W+OFFSET_W-1:OFFSET_W];
    assign w_off    = r_addr[OFFSET_W-1:0];
    assign w_hit    = w_line_valid && (w_line_tag == w_tag);
    assign w_flush  = (r_state == S_IDLE) && bus.flush;
    assign w_refill = (r_state == S_REFILL) && !rst;

    dm_cache_lines #(
        .INDEX_W  (INDEX_W),
        .TAG_BITS (TAG_BITS)
    ) u_lines (
        .clk        (clk),
        .rst        (rst),
        .i_flush    (w_flush),
        .i_rd_idx   (w_idx),
        .o_rd_valid (w_line_valid),
        .o_rd_tag   (w_line_tag),
        .o_rd_data  (w_line_data),
        .i_wr_en    (w_refill),
        .i_wr_idx   (w_idx),
        .i_wr_tag   (w_tag),
        .i_wr_data  (r_block)
    );

    // The word is staged in r_word so resp_data only moves with the resp_valid pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_addr       <= '0;
            r_mem_addr   <= '0;
            r_lat_cnt    <= '0;
            r_block      <= '0;
            r_word       <= '0;
            r_word_hit   <= 1'b0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
            r_resp_hit   <= 1'b0;
            r_hit_cnt    <= '0;
            r_miss_cnt   <= '0;
        end else begin
            r_resp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!bus.flush && bus.req_valid) begin
                        r_addr      <= bus.req_addr;
                        r_req_ready <= 1'b0;
                        r_state     <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (w_hit) begin
                        r_word     <= word_sel(w_line_data, w_off);
                        r_word_hit <= 1'b1;
                        if (r_hit_cnt != '1) r_hit_cnt <= r_hit_cnt + 1'b1;
                        r_state    <= S_RESP;
                    end else begin
                        if (r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + 1'b1;
                        r_mem_addr <= {r_addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
                        r_lat_cnt  <= '0;
                        r_state    <= S_MEM_WAIT;
                    end
                end
                S_MEM_WAIT: begin
                    if (r_lat_cnt == 4'(MEM_LAT - 1)) begin
                        r_block <= bus.mem_rdata;
                        r_state <= S_REFILL;
                    end else begin
                        r_lat_cnt <= r_lat_cnt + 1'b1;
                    end
                end
                S_REFILL: begin
                    r_word     <= word_sel(r_block, w_off);
                    r_word_hit <= 1'b0;
                    r_state    <= S_RESP;
                end
                S_RESP: begin
                    r_resp_valid <= 1'b1;
                    r_resp_data  <= r_word;
                    r_resp_hit   <= r_word_hit;
                    r_req_ready  <= 1'b1;
                    r_state      <= S_IDLE;
                end
                default: begin
                    r_req_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready  = r_req_ready;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_data  = r_resp_data;
    assign bus.resp_hit   = r_resp_hit;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.hit_count  = r_hit_cnt;
    assign bus.miss_count = r_miss_cnt;
endmodule
